// File: rtl/sram_pkg.sv
// Shared types for the SRAM port arbiter: channel ids, return tags and the
// command layout at the default 32-bit address/data widths.
package sram_pkg;

  localparam int MAX_CH     = 8;
  localparam int CH_ID_W    = 3;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Sized for the largest supported channel count so one id type serves every configuration.
  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t chId;
  } rd_tag_t;

  typedef struct packed {
    logic                    we;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
    logic [DEF_DATA_W/8-1:0] wmask;
  } sram_cmd_t;

  function automatic ch_id_t nextId(input ch_id_t id, input int numCh);
    return (int'(id) >= numCh - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around, then moves the pointer just past the winner.
module rr_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] gnt_o,
  output ch_id_t            winner_o
);

  ch_id_t ptr_q, ptr_d;
  logic   found;
  int     win;

  // Two passes: first the channels at or above the pointer, then the wrapped-around ones.
  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    win      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        win   = i;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        win   = i;
      end
    end
    if (found && !rst) begin
      winner_o = ch_id_t'(win);
      for (int i = 0; i < NUM_CH; i++) begin
        gnt_o[i] = (i == win);
      end
      ptr_d = nextId(ch_id_t'(win), NUM_CH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between NUM_CH requesters: arbitrates, issues the
// winning command from registers, and steers read data back by a tag pipe.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter  int NUM_CH     = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int RD_LATENCY = 1,
  localparam int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
  input  logic [NUM_CH*NUM_BYTES-1:0]    ch_wmask,
  output logic [NUM_CH-1:0]              ch_gnt,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [DATA_WIDTH-1:0]          ch_rdata,
  output logic                           sram_rd_en,
  output logic [ADDR_WIDTH-1:0]          sram_rd_addr,
  output logic                           sram_wr_en,
  output logic [ADDR_WIDTH-1:0]          sram_wr_addr,
  output logic [DATA_WIDTH-1:0]          sram_wr_data,
  output logic [NUM_BYTES-1:0]           sram_w_mask,
  input  logic                           sram_rd_valid,
  input  logic [DATA_WIDTH-1:0]          sram_rd_data,
  output logic                           err_rd_mismatch
);

  logic [NUM_CH-1:0]     gnt;
  ch_id_t                winner;
  logic                  selWe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic [NUM_BYTES-1:0]  selWmask;

  logic                  rdEn_q, rdEn_d, wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d, wrAddr_q, wrAddr_d;
  logic [DATA_WIDTH-1:0] wrData_q, wrData_d;
  logic [NUM_BYTES-1:0]  wMask_q, wMask_d;
  ch_id_t                rdCh_q, rdCh_d;
  rd_tag_t               tagPipe_q [RD_LATENCY];
  rd_tag_t               tail;
  logic                  errMismatch_q, errMismatch_d;

  rr_arbiter #(.NUM_CH(NUM_CH)) uArb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (ch_req),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign ch_gnt = gnt;

  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    selWmask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        selWe    = ch_we[i];
        selAddr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selWdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        selWmask = ch_wmask[i*NUM_BYTES +: NUM_BYTES];
      end
    end
  end

  // Address, data and mask registers only load on their own command type, so they hold when idle.
  always_comb begin
    rdEn_d   = (|gnt) && !selWe;
    wrEn_d   = (|gnt) && selWe;
    rdAddr_d = rdEn_d ? selAddr : rdAddr_q;
    rdCh_d   = rdEn_d ? winner : rdCh_q;
    wrAddr_d = wrEn_d ? selAddr : wrAddr_q;
    wrData_d = wrEn_d ? selWdata : wrData_q;
    wMask_d  = wrEn_d ? selWmask : wMask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdEn_q   <= 1'b0;
      wrEn_q   <= 1'b0;
      rdAddr_q <= '0;
      rdCh_q   <= '0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      wMask_q  <= '0;
    end else begin
      rdEn_q   <= rdEn_d;
      wrEn_q   <= wrEn_d;
      rdAddr_q <= rdAddr_d;
      rdCh_q   <= rdCh_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      wMask_q  <= wMask_d;
    end
  end

  // The tag enters on the cycle the strobe is on the SRAM, so the tail lines up with returning data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        tagPipe_q[k] <= '0;
      end
    end else begin
      tagPipe_q[0] <= '{valid: rdEn_q, chId: rdCh_q};
      for (int k = 1; k < RD_LATENCY; k++) begin
        tagPipe_q[k] <= tagPipe_q[k-1];
      end
    end
  end

  assign tail = tagPipe_q[RD_LATENCY-1];

  always_comb begin
    ch_rvalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rvalid[i] = tail.valid && (tail.chId == ch_id_t'(i));
    end
  end

  assign ch_rdata      = tail.valid ? sram_rd_data : '0;
  assign errMismatch_d = errMismatch_q || (sram_rd_valid != tail.valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errMismatch_q <= 1'b0;
    end else begin
      errMismatch_q <= errMismatch_d;
    end
  end

  assign sram_rd_en      = rdEn_q;
  assign sram_rd_addr    = rdAddr_q;
  assign sram_wr_en      = wrEn_q;
  assign sram_wr_addr    = wrAddr_q;
  assign sram_wr_data    = wrData_q;
  assign sram_w_mask     = wMask_q;
  assign err_rd_mismatch = errMismatch_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (3 channels, read latency 3) with a
// behavioural SRAM whose read return can be delayed one extra cycle.
module tb_sram_port_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int NB  = DW / 8;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   chReq, chWe, chGnt, chRvalid;
  logic [NCH*AW-1:0] chAddr;
  logic [NCH*DW-1:0] chWdata;
  logic [NCH*NB-1:0] chWmask;
  logic [DW-1:0]    chRdata;
  logic             sramRdEn, sramWrEn, sramRdValid, errRdMismatch;
  logic [AW-1:0]    sramRdAddr, sramWrAddr;
  logic [DW-1:0]    sramWrData, sramRdData;
  logic [NB-1:0]    sramWMask;

  int vecCount  = 0;
  int missCount = 0;
  logic lateMode;

  logic [31:0] mem [0:255];
  logic [4:0]  rdvPipe;
  logic [31:0] rddPipe [0:4];

  logic [2:0]  t4Req    [0:7] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [2:0]  t4Gnt    [0:7] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic        t4RdEn   [0:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] t4RdAddr [0:7] = '{32'h0, 32'h200, 32'h204, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [2:0]  t4Rvalid [0:7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
  logic [31:0] t4Rdata  [0:7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hC0DE0080, 32'hC0DE0081, 32'hC0DE0082, 32'h0};

  sram_port_arbiter #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_req          (chReq),
    .ch_we           (chWe),
    .ch_addr         (chAddr),
    .ch_wdata        (chWdata),
    .ch_wmask        (chWmask),
    .ch_gnt          (chGnt),
    .ch_rvalid       (chRvalid),
    .ch_rdata        (chRdata),
    .sram_rd_en      (sramRdEn),
    .sram_rd_addr    (sramRdAddr),
    .sram_wr_en      (sramWrEn),
    .sram_wr_addr    (sramWrAddr),
    .sram_wr_data    (sramWrData),
    .sram_w_mask     (sramWMask),
    .sram_rd_valid   (sramRdValid),
    .sram_rd_data    (sramRdData),
    .err_rd_mismatch (errRdMismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
  end

  // SRAM model: byte-masked writes, reads return LAT cycles after the strobe (LAT+1 in late mode).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdvPipe <= '0;
      for (int k = 0; k < 5; k++) rddPipe[k] <= '0;
    end else begin
      rdvPipe    <= {rdvPipe[3:0], sramRdEn};
      rddPipe[0] <= mem[sramRdAddr[9:2]];
      for (int k = 1; k < 5; k++) rddPipe[k] <= rddPipe[k-1];
      if (sramWrEn) begin
        for (int b = 0; b < NB; b++) begin
          if (sramWMask[b]) mem[sramWrAddr[9:2]][8*b +: 8] <= sramWrData[8*b +: 8];
        end
      end
    end
  end

  assign sramRdValid = lateMode ? rdvPipe[LAT] : rdvPipe[LAT-1];
  assign sramRdData  = lateMode ? rddPipe[LAT] : rddPipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] req);
    chReq = req;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] seen;
    rst = 1'b1; chReq = '0; chWe = '0; chAddr = '0; chWdata = '0; chWmask = '0; lateMode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gnt", chGnt, 0);
    checkOutput("rst_rden", sramRdEn, 0);
    checkOutput("rst_wren", sramWrEn, 0);
    checkOutput("rst_rvalid", chRvalid, 0);
    checkOutput("rst_err", errRdMismatch, 0);
    rst = 1'b0;

    $display("[TB] single read, ch0");
    chAddr[0 +: 32] = 32'h100;
    applyStimulus(3'b001);
    #2 checkOutput("t1_gnt", chGnt, 3'b001);
    nextCycle(); applyStimulus(3'b000);
    #2 checkOutput("t1_rden", sramRdEn, 1);
    checkOutput("t1_rdaddr", sramRdAddr, 32'h100);
    checkOutput("t1_wren", sramWrEn, 0);
    nextCycle(); nextCycle();
    #2 checkOutput("t1_rvalid_early", chRvalid, 3'b000);
    nextCycle();
    #2 checkOutput("t1_rvalid", chRvalid, 3'b001);
    checkOutput("t1_rdata", chRdata, 32'hC0DE0040);
    nextCycle();

    $display("[TB] round-robin between ch0 and ch1");
    doReset();
    chAddr[0 +: 32] = 32'h000; chAddr[32 +: 32] = 32'h004;
    applyStimulus(3'b011);
    for (int i = 0; i < 4; i++) begin
      #2 checkOutput("t2_gnt", chGnt, (i % 2 == 0) ? 3'b001 : 3'b010);
      nextCycle();
    end
    applyStimulus(3'b000);
    repeat (6) nextCycle();

    $display("[TB] masked write then read-back");
    chWe = 3'b010; chAddr[32 +: 32] = 32'h40; chWdata[32 +: 32] = 32'hDEADBEEF; chWmask[4 +: 4] = 4'b0011;
    applyStimulus(3'b010);
    #2 checkOutput("t3_wgnt", chGnt, 3'b010);
    nextCycle();
    chWe = 3'b000; chAddr[0 +: 32] = 32'h40;
    applyStimulus(3'b001);
    #2 checkOutput("t3_wren", sramWrEn, 1);
    checkOutput("t3_rden_off", sramRdEn, 0);
    checkOutput("t3_wraddr", sramWrAddr, 32'h40);
    checkOutput("t3_wrdata", sramWrData, 32'hDEADBEEF);
    checkOutput("t3_wmask", sramWMask, 4'b0011);
    checkOutput("t3_rgnt", chGnt, 3'b001);
    nextCycle(); applyStimulus(3'b000);
    #2 checkOutput("t3_rden", sramRdEn, 1);
    checkOutput("t3_wren_off", sramWrEn, 0);
    checkOutput("t3_wraddr_hold", sramWrAddr, 32'h40);
    checkOutput("t3_rdaddr", sramRdAddr, 32'h40);
    repeat (3) nextCycle();
    #2 checkOutput("t3_rvalid", chRvalid, 3'b001);
    checkOutput("t3_rdata", chRdata, 32'hC0DEBEEF);
    nextCycle();

    $display("[TB] back-to-back reads from three channels");
    doReset();
    chAddr[0 +: 32] = 32'h200; chAddr[32 +: 32] = 32'h204; chAddr[64 +: 32] = 32'h208;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(t4Req[c]);
      #2 checkOutput("t4_gnt", chGnt, t4Gnt[c]);
      checkOutput("t4_rden", sramRdEn, t4RdEn[c]);
      if (t4RdEn[c]) checkOutput("t4_rdaddr", sramRdAddr, t4RdAddr[c]);
      checkOutput("t4_rvalid", chRvalid, t4Rvalid[c]);
      if (t4Rvalid[c] != 3'b000) checkOutput("t4_rdata", chRdata, t4Rdata[c]);
      nextCycle();
    end

    $display("[TB] reset with reads in flight");
    chAddr[0 +: 32] = 32'h100; chAddr[32 +: 32] = 32'h104;
    applyStimulus(3'b011);
    #2 checkOutput("t5_gnt0", chGnt, 3'b001);
    nextCycle(); applyStimulus(3'b010);
    #2 checkOutput("t5_gnt1", chGnt, 3'b010);
    nextCycle(); applyStimulus(3'b001);
    rst = 1'b1;
    #1 checkOutput("t5_rst_rden", sramRdEn, 0);
    checkOutput("t5_rst_gnt", chGnt, 0);
    checkOutput("t5_rst_rvalid", chRvalid, 0);
    nextCycle(); nextCycle();
    rst = 1'b0; applyStimulus(3'b000);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      #2 seen = seen | chRvalid;
      nextCycle();
    end
    checkOutput("t5_no_rvalid", seen, 3'b000);
    checkOutput("t5_err", errRdMismatch, 0);
    applyStimulus(3'b110);
    #2 checkOutput("t5_ptr0", chGnt, 3'b010);
    nextCycle(); applyStimulus(3'b000);
    repeat (6) nextCycle();

    $display("[TB] late read-valid from SRAM");
    doReset();
    lateMode = 1'b1;
    applyStimulus(3'b001);
    #2 checkOutput("t6_gnt", chGnt, 3'b001);
    nextCycle(); applyStimulus(3'b000);
    repeat (2) nextCycle();
    #2 checkOutput("t6_err_before", errRdMismatch, 0);
    nextCycle();
    #2 checkOutput("t6_rvalid_tail", chRvalid, 3'b001);
    nextCycle();
    #2 checkOutput("t6_err_set", errRdMismatch, 1);
    repeat (4) nextCycle();
    #2 checkOutput("t6_err_held", errRdMismatch, 1);
    lateMode = 1'b0;
    rst = 1'b1;
    #1 checkOutput("t6_err_clr", errRdMismatch, 0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
